// File: rtl/alu_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module : alu_unit_if                                                        |
// | Brief  : Operand/decode bundle feeding alu_unit and its registered result.  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_unit_if;
    logic        op;
    logic        op_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;

    modport master (
        output op, op_imm, funct3, funct7, a, b,
        input  t
    );

    modport slave (
        input  op, op_imm, funct3, funct7, a, b,
        output t
    );
endinterface

`default_nettype wire

// File: rtl/alu_unit.sv
// +----------------------------------------------------------------------------+
// | Module : alu_unit                                                           |
// | Brief  : Registered RV32I integer ALU, one-cycle latency, fixed 32 bits.    |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_unit (
    input  wire         clk,
    input  wire         rst,
    alu_unit_if.slave   bus
);

    localparam logic [2:0] c_f3_add  = 3'b000;
    localparam logic [2:0] c_f3_sl   = 3'b001;
    localparam logic [2:0] c_f3_slt  = 3'b010;
    localparam logic [2:0] c_f3_sltu = 3'b011;
    localparam logic [2:0] c_f3_xor  = 3'b100;
    localparam logic [2:0] c_f3_sr   = 3'b101;
    localparam logic [2:0] c_f3_or   = 3'b110;
    localparam logic [2:0] c_f3_and  = 3'b111;

    logic        w_decode_en;
    logic        w_sub;
    logic        w_sra;
    logic [4:0]  w_shamt;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_srl;
    logic [31:0] w_sra_res;
    logic        w_lt_s;
    logic        w_lt_u;
    logic [31:0] w_result;
    logic [31:0] r_t;

    // Remaining funct7 bits carry immediate/opcode info we deliberately ignore.
    wire w_unused = &{1'b0, bus.funct7[6], bus.funct7[4:0]};

    // R-type wins over OP-IMM; with neither set the ALU acts as an address adder.
    assign w_decode_en = bus.op | bus.op_imm;
    assign w_sub       = bus.op & bus.funct7[5];
    assign w_sra       = w_decode_en & bus.funct7[5];
    assign w_shamt     = bus.b[4:0];

    assign w_sum     = bus.a + bus.b;
    assign w_diff    = bus.a - bus.b;
    assign w_srl     = bus.a >> w_shamt;
    assign w_sra_res = $unsigned($signed(bus.a) >>> w_shamt);
    assign w_lt_s    = $signed(bus.a) < $signed(bus.b);
    assign w_lt_u    = bus.a < bus.b;

    always_comb begin
        w_result = w_sum;
        if (w_decode_en) begin
            case (bus.funct3)
                c_f3_add:  w_result = w_sub ? w_diff : w_sum;
                c_f3_sl:   w_result = bus.a << w_shamt;
                c_f3_slt:  w_result = {31'd0, w_lt_s};
                c_f3_sltu: w_result = {31'd0, w_lt_u};
                c_f3_xor:  w_result = bus.a ^ bus.b;
                c_f3_sr:   w_result = w_sra ? w_sra_res : w_srl;
                c_f3_or:   w_result = bus.a | bus.b;
                c_f3_and:  w_result = bus.a & bus.b;
                default:   w_result = w_sum;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t <= 32'd0;
        end else begin
            r_t <= w_result;
        end
    end

    assign bus.t = r_t;

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
// +----------------------------------------------------------------------------+
// | Module : tb_alu_unit                                                        |
// | Brief  : Directed-vector self-checking bench for alu_unit.                  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_unit;

    logic clk;
    logic rst;
    int   r_total;
    int   r_passed;

    alu_unit_if u_if ();

    alu_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total = r_total + 1;
        if (got === exp) begin
            r_passed = r_passed + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; result sampled 1 unit after the next.
    task automatic vec(input string tag, input logic op, input logic op_imm,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        u_if.op     = op;
        u_if.op_imm = op_imm;
        u_if.funct3 = f3;
        u_if.funct7 = f7;
        u_if.a      = a;
        u_if.b      = b;
        @(posedge clk);
        #1;
        check(tag, u_if.t, exp);
    endtask

    initial begin
        r_total  = 0;
        r_passed = 0;
        rst         = 1'b1;
        u_if.op     = 1'b1;
        u_if.op_imm = 1'b0;
        u_if.funct3 = 3'b000;
        u_if.funct7 = 7'h00;
        u_if.a      = 32'd5;
        u_if.b      = 32'd6;
        #2;
        check("reset_t", u_if.t, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", u_if.t, 32'd0);
        rst = 1'b0;

        // Neither mode bit: always a+b
        for (int f3 = 0; f3 < 8; f3++) begin
            vec("plain_add_f7lo", 1'b0, 1'b0, 3'(f3), 7'h00, 32'd998244353, 32'd10000007, 32'd1008244360);
            vec("plain_add_f7hi", 1'b0, 1'b0, 3'(f3), 7'h20, 32'd998244353, 32'd10000007, 32'd1008244360);
        end

        // R-type, small positives
        vec("r_add",  1'b1, 1'b0, 3'b000, 7'h00, 32'd20, 32'd7, 32'd27);
        vec("r_sub",  1'b1, 1'b0, 3'b000, 7'h20, 32'd20, 32'd7, 32'd13);
        vec("r_sl",   1'b1, 1'b0, 3'b001, 7'h00, 32'd20, 32'd7, 32'd2560);
        vec("r_slt",  1'b1, 1'b0, 3'b010, 7'h00, 32'd20, 32'd7, 32'd0);
        vec("r_sltu", 1'b1, 1'b0, 3'b011, 7'h00, 32'd20, 32'd7, 32'd0);
        vec("r_xor",  1'b1, 1'b0, 3'b100, 7'h00, 32'd20, 32'd7, 32'd19);
        vec("r_srl",  1'b1, 1'b0, 3'b101, 7'h00, 32'd20, 32'd7, 32'd0);
        vec("r_sra",  1'b1, 1'b0, 3'b101, 7'h20, 32'd20, 32'd7, 32'd0);
        vec("r_or",   1'b1, 1'b0, 3'b110, 7'h00, 32'd20, 32'd7, 32'd23);
        vec("r_and",  1'b1, 1'b0, 3'b111, 7'h00, 32'd20, 32'd7, 32'd4);

        // R-type, negative operand
        vec("n_add",  1'b1, 1'b0, 3'b000, 7'h00, 32'hFFFFFF9C, 32'd4, 32'hFFFFFFA0);
        vec("n_sub",  1'b1, 1'b0, 3'b000, 7'h20, 32'hFFFFFF9C, 32'd4, 32'hFFFFFF98);
        vec("n_sl",   1'b1, 1'b0, 3'b001, 7'h00, 32'hFFFFFF9C, 32'd4, 32'hFFFFF9C0);
        vec("n_slt",  1'b1, 1'b0, 3'b010, 7'h00, 32'hFFFFFF9C, 32'd4, 32'd1);
        vec("n_sltu", 1'b1, 1'b0, 3'b011, 7'h00, 32'hFFFFFF9C, 32'd4, 32'd0);
        vec("n_xor",  1'b1, 1'b0, 3'b100, 7'h00, 32'hFFFFFF9C, 32'd4, 32'hFFFFFF98);
        vec("n_srl",  1'b1, 1'b0, 3'b101, 7'h00, 32'hFFFFFF9C, 32'd4, 32'h0FFFFFF9);
        vec("n_sra",  1'b1, 1'b0, 3'b101, 7'h20, 32'hFFFFFF9C, 32'd4, 32'hFFFFFFF9);
        vec("n_or",   1'b1, 1'b0, 3'b110, 7'h00, 32'hFFFFFF9C, 32'd4, 32'hFFFFFF9C);
        vec("n_and",  1'b1, 1'b0, 3'b111, 7'h00, 32'hFFFFFF9C, 32'd4, 32'd4);

        // Signed vs unsigned compare; shift amount masked to b[4:0]=0
        vec("m_add",  1'b1, 1'b0, 3'b000, 7'h00, 32'd10000000, 32'hFF676980, 32'd0);
        vec("m_slt",  1'b1, 1'b0, 3'b010, 7'h00, 32'd10000000, 32'hFF676980, 32'd0);
        vec("m_sltu", 1'b1, 1'b0, 3'b011, 7'h00, 32'd10000000, 32'hFF676980, 32'd1);
        vec("m_sl",   1'b1, 1'b0, 3'b001, 7'h00, 32'd10000000, 32'hFF676980, 32'd10000000);
        vec("m_srl",  1'b1, 1'b0, 3'b101, 7'h00, 32'd10000000, 32'hFF676980, 32'd10000000);
        vec("m_sra",  1'b1, 1'b0, 3'b101, 7'h20, 32'd10000000, 32'hFF676980, 32'd10000000);

        // Qualifier handling and mode priority
        vec("i_addi_f7hi", 1'b0, 1'b1, 3'b000, 7'h20, 32'd20, 32'd7, 32'd27);
        vec("i_srai",      1'b0, 1'b1, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000);
        vec("i_srli",      1'b0, 1'b1, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000);
        vec("i_slti",      1'b0, 1'b1, 3'b010, 7'h00, 32'hFFFFFF9C, 32'd4, 32'd1);
        vec("prio_sub",    1'b1, 1'b1, 3'b000, 7'h20, 32'd20, 32'd7, 32'd13);
        vec("f7_other",    1'b1, 1'b0, 3'b000, 7'h5F, 32'd20, 32'd7, 32'd27);

        // Asynchronous reset mid-cycle while t is nonzero
        vec("pre_rst", 1'b1, 1'b0, 3'b110, 7'h00, 32'h12340000, 32'h00005678, 32'h12345678);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", u_if.t, 32'd0);
        u_if.op     = 1'b1;
        u_if.op_imm = 1'b0;
        u_if.funct3 = 3'b000;
        u_if.funct7 = 7'h00;
        u_if.a      = 32'd1;
        u_if.b      = 32'd2;
        @(posedge clk);
        #1;
        check("rst_hold_edge", u_if.t, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_add", u_if.t, 32'd3);

        $display("%0d/%0d checks passed", r_passed, r_total);
        $finish;
    end

endmodule

`default_nettype wire
